// File: rtl/noc_ni_packetizer.sv
// ---------------------------------------------------------------------------
// noc_ni_packetizer
//
// Transmit side of a network interface. Converts a core-side message
// (destination YX address + length descriptor, followed by payload words)
// into a NoC packet. The packet is a head flit, then body flits, with the
// last one marked as the tail. It drives the router's local input port
// through a fully registered valid/ready output stage.
//
// Ports:
//   clk_i          clock
//   rst_n_i        asynchronous active-low reset
//   router_addr_i  this node's YX address (source field of the head flit)
//   msg_valid_i    message descriptor valid
//   msg_ready_o    message descriptor accepted
//   msg_dest_i     destination YX address, [7:4]=X, [3:0]=Y
//   msg_len_i      number of payload words (0..255)
//   data_valid_i   payload word valid
//   data_ready_o   payload word accepted
//   data_i         payload word
//   flit_valid_o   output flit valid
//   flit_ready_i   router local port can accept a flit
//   flit_o         {type[1:0], data}; 01 head, 00 body, 10 tail, 11 head+tail
//   busy_o         packet body in progress
//   len_err_o      one-cycle pulse: descriptor length exceeded MAX_LEN
// ---------------------------------------------------------------------------
module noc_ni_packetizer #(
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [7:0]        router_addr_i,
    input  logic              msg_valid_i,
    output logic              msg_ready_o,
    input  logic [7:0]        msg_dest_i,
    input  logic [7:0]        msg_len_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              flit_valid_o,
    input  logic              flit_ready_i,
    output logic [DATA_W+1:0] flit_o,
    output logic              busy_o,
    output logic              len_err_o
);

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_BODY = 1'b1;

    localparam logic [1:0] TYPE_BODY      = 2'b00;
    localparam logic [1:0] TYPE_HEAD      = 2'b01;
    localparam logic [1:0] TYPE_TAIL      = 2'b10;
    localparam logic [1:0] TYPE_HEAD_TAIL = 2'b11;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    logic [0:0]        state_q, state_d;
    logic [7:0]        seq_q, seq_d;
    logic [7:0]        rem_q, rem_d;
    logic              flit_valid_q, flit_valid_d;
    logic [DATA_W+1:0] flit_q, flit_d;
    logic              len_err_q, len_err_d;

    logic              can_load;
    logic              msg_fire;
    logic              data_fire;
    logic              len_over;
    logic [7:0]        len_eff;
    logic [DATA_W-1:0] head_data;

    // The output register may take a new flit whenever it is empty or is
    // being drained in this same cycle.
    assign can_load = !flit_valid_q || flit_ready_i;

    // Readies are forced low during reset so no handshake can be counted
    // by the core while the packetizer is being cleared.
    assign msg_ready_o  = rst_n_i && (state_q == STATE_IDLE) && can_load;
    assign data_ready_o = rst_n_i && (state_q == STATE_BODY) && can_load;

    assign msg_fire  = msg_valid_i  && msg_ready_o;
    assign data_fire = data_valid_i && data_ready_o;

    // Over-long messages are clipped: the head advertises MAX_LEN and only
    // that many payload words are consumed.
    assign len_over = (msg_len_i > MAX_LEN_B);
    assign len_eff  = len_over ? MAX_LEN_B : msg_len_i;

    always_comb begin
        head_data       = '0;
        head_data[31:0] = {seq_q, len_eff, router_addr_i, msg_dest_i};
    end

    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        rem_d        = rem_q;
        flit_valid_d = flit_valid_q;
        flit_d       = flit_q;
        len_err_d    = 1'b0;

        // Drain: the register empties unless a new flit replaces it below.
        if (flit_valid_q && flit_ready_i) begin
            flit_valid_d = 1'b0;
        end

        if (msg_fire) begin
            flit_valid_d = 1'b1;
            seq_d        = seq_q + 8'd1;
            len_err_d    = len_over;
            if (msg_len_i == 8'd0) begin
                flit_d = {TYPE_HEAD_TAIL, head_data};
            end else begin
                flit_d  = {TYPE_HEAD, head_data};
                rem_d   = len_eff;
                state_d = STATE_BODY;
            end
        end else if (data_fire) begin
            flit_valid_d = 1'b1;
            rem_d        = rem_q - 8'd1;
            if (rem_q == 8'd1) begin
                flit_d  = {TYPE_TAIL, data_i};
                state_d = STATE_IDLE;
            end else begin
                flit_d = {TYPE_BODY, data_i};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= STATE_IDLE;
            seq_q        <= 8'd0;
            rem_q        <= 8'd0;
            flit_valid_q <= 1'b0;
            flit_q       <= '0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            rem_q        <= rem_d;
            flit_valid_q <= flit_valid_d;
            flit_q       <= flit_d;
            len_err_q    <= len_err_d;
        end
    end

    assign flit_valid_o = flit_valid_q;
    assign flit_o       = flit_q;
    assign busy_o       = (state_q == STATE_BODY);
    assign len_err_o    = len_err_q;

endmodule

// File: tb/tb_noc_ni_packetizer.sv
`timescale 1ns/1ps
module tb_noc_ni_packetizer;

    localparam int DW = 32;
    localparam int ML = 4;

    logic          clk;
    logic          rst_n;
    logic [7:0]    router_addr;
    logic          msg_valid;
    logic          msg_ready;
    logic [7:0]    msg_dest;
    logic [7:0]    msg_len;
    logic          data_valid;
    logic          data_ready;
    logic [DW-1:0] data;
    logic          flit_valid;
    logic          flit_ready;
    logic [DW+1:0] flit;
    logic          busy;
    logic          len_err;

    int checks   = 0;
    int failures = 0;

    noc_ni_packetizer #(.DATA_W(DW), .MAX_LEN(ML)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .router_addr_i(router_addr),
        .msg_valid_i  (msg_valid),
        .msg_ready_o  (msg_ready),
        .msg_dest_i   (msg_dest),
        .msg_len_i    (msg_len),
        .data_valid_i (data_valid),
        .data_ready_o (data_ready),
        .data_i       (data),
        .flit_valid_o (flit_valid),
        .flit_ready_i (flit_ready),
        .flit_o       (flit),
        .busy_o       (busy),
        .len_err_o    (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  dest;
        logic [7:0]  len;
        logic [33:0] head;
        logic        err;
        int          nb;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge; inputs are driven here and
    // outputs are read 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input int v, input int i);
        return 32'hA000_0000 | 32'(v << 8) | 32'(i);
    endfunction

    initial begin
        // Headline vectors, consumed in order starting from seq=0.
        vecs[0] = '{dest: 8'h34, len: 8'd2, head: {2'b01, 32'h00021234}, err: 1'b0, nb: 2};
        vecs[1] = '{dest: 8'h00, len: 8'd0, head: {2'b11, 32'h01001200}, err: 1'b0, nb: 0};
        vecs[2] = '{dest: 8'h56, len: 8'd9, head: {2'b01, 32'h02041256}, err: 1'b1, nb: 4};
        vecs[3] = '{dest: 8'h12, len: 8'd1, head: {2'b01, 32'h03011212}, err: 1'b0, nb: 1};
        vecs[4] = '{dest: 8'h7F, len: 8'd4, head: {2'b01, 32'h0404127F}, err: 1'b0, nb: 4};

        rst_n       = 1'b0;
        router_addr = 8'h12;
        msg_valid   = 1'b0;
        msg_dest    = 8'h00;
        msg_len     = 8'h00;
        data_valid  = 1'b0;
        data        = '0;
        flit_ready  = 1'b1;

        #12;
        chk("rst_flit_valid", 64'(flit_valid), 64'd0);
        chk("rst_flit",       64'(flit),       64'd0);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_len_err",    64'(len_err),    64'd0);
        chk("rst_msg_ready",  64'(msg_ready),  64'd0);
        chk("rst_data_ready", 64'(data_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- table-driven messages ----------------
        for (int v = 0; v < 5; v++) begin
            msg_valid = 1'b1;
            msg_dest  = vecs[v].dest;
            msg_len   = vecs[v].len;
            #1;
            chk($sformatf("v%0d_msg_ready", v), 64'(msg_ready), 64'd1);
            chk($sformatf("v%0d_data_ready_idle", v), 64'(data_ready), 64'd0);
            tick();
            msg_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_head_valid", v), 64'(flit_valid), 64'd1);
            chk($sformatf("v%0d_head", v), 64'(flit), 64'(vecs[v].head));
            chk($sformatf("v%0d_len_err", v), 64'(len_err), 64'(vecs[v].err));
            chk($sformatf("v%0d_busy_head", v), 64'(busy), 64'(vecs[v].nb > 0));
            for (int i = 0; i < vecs[v].nb; i++) begin
                data_valid = 1'b1;
                data       = word(v, i);
                #1;
                chk($sformatf("v%0d_data_ready%0d", v, i), 64'(data_ready), 64'd1);
                tick();
                #1;
                chk($sformatf("v%0d_flit%0d", v, i), 64'(flit),
                    64'({(i == vecs[v].nb - 1) ? 2'b10 : 2'b00, word(v, i)}));
                chk($sformatf("v%0d_valid%0d", v, i), 64'(flit_valid), 64'd1);
                chk($sformatf("v%0d_busy%0d", v, i), 64'(busy), 64'(i != vecs[v].nb - 1));
                if (i == 0)
                    chk($sformatf("v%0d_len_err_clr", v), 64'(len_err), 64'd0);
            end
            data_valid = 1'b0;
            tick();
            #1;
            chk($sformatf("v%0d_drained", v), 64'(flit_valid), 64'd0);
            chk($sformatf("v%0d_len_err_idle", v), 64'(len_err), 64'd0);
        end

        // ---------------- backpressure mid-body (seq 5) ----------------
        msg_valid = 1'b1; msg_dest = 8'h21; msg_len = 8'd3;
        tick();
        msg_valid = 1'b0;
        #1;
        chk("bp_head", 64'(flit), 64'({2'b01, 32'h05031221}));
        data_valid = 1'b1; data = 32'hB0B0_0000;
        tick();
        #1;
        chk("bp_body0", 64'(flit), 64'({2'b00, 32'hB0B0_0000}));
        flit_ready = 1'b0;
        data       = 32'hB0B0_0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_data_ready_hold%0d", k), 64'(data_ready), 64'd0);
            tick();
            #1;
            chk($sformatf("bp_flit_hold%0d", k), 64'(flit), 64'({2'b00, 32'hB0B0_0000}));
            chk($sformatf("bp_valid_hold%0d", k), 64'(flit_valid), 64'd1);
        end
        flit_ready = 1'b1;
        #1;
        chk("bp_data_ready_rel", 64'(data_ready), 64'd1);
        tick();
        #1;
        chk("bp_body1", 64'(flit), 64'({2'b00, 32'hB0B0_0001}));
        data = 32'hB0B0_0002;
        tick();
        #1;
        chk("bp_tail", 64'(flit), 64'({2'b10, 32'hB0B0_0002}));
        data_valid = 1'b0;
        tick();
        #1;
        chk("bp_drained", 64'(flit_valid), 64'd0);

        // ---------------- reset mid-packet (seq 6, len clipped) ----------------
        msg_valid = 1'b1; msg_dest = 8'h44; msg_len = 8'd5;
        tick();
        msg_valid = 1'b0;
        #1;
        chk("mr_head", 64'(flit), 64'({2'b01, 32'h06041244}));
        chk("mr_len_err", 64'(len_err), 64'd1);
        data_valid = 1'b1; data = 32'hC000_0000;
        tick();
        data = 32'hC000_0001;
        tick();
        #1;
        chk("mr_body1", 64'(flit), 64'({2'b00, 32'hC000_0001}));
        rst_n = 1'b0;
        data_valid = 1'b0;
        #1;
        chk("mr_flit_valid", 64'(flit_valid), 64'd0);
        chk("mr_flit",       64'(flit),       64'd0);
        chk("mr_busy",       64'(busy),       64'd0);
        chk("mr_msg_ready",  64'(msg_ready),  64'd0);
        chk("mr_data_ready", 64'(data_ready), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- back-to-back len=1 messages after reset ----------------
        msg_valid = 1'b1; msg_dest = 8'h9A; msg_len = 8'd1;
        tick();
        msg_valid = 1'b0;
        #1;
        chk("bb_head0", 64'(flit), 64'({2'b01, 32'h0001129A}));
        data_valid = 1'b1; data = 32'hD000_0000;
        tick();
        data_valid = 1'b0;
        #1;
        chk("bb_tail0", 64'(flit), 64'({2'b10, 32'hD000_0000}));
        msg_valid = 1'b1; msg_dest = 8'h9B;
        #1;
        chk("bb_msg_ready", 64'(msg_ready), 64'd1);
        tick();
        msg_valid = 1'b0;
        #1;
        chk("bb_head1", 64'(flit), 64'({2'b01, 32'h0101129B}));
        chk("bb_head1_valid", 64'(flit_valid), 64'd1);
        data_valid = 1'b1; data = 32'hD000_0001;
        tick();
        data_valid = 1'b0;
        #1;
        chk("bb_tail1", 64'(flit), 64'({2'b10, 32'hD000_0001}));
        tick();
        #1;
        chk("bb_drained", 64'(flit_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
